// File: rtl/dcache_pkg.sv
// Shared types for the set-associative data cache controller.
package dcache_pkg;

  // Controller states: single outstanding LSU request, serialised memory traffic.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  // Way-select width; a direct-mapped cache still carries a 1-bit way field.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Width of one packed line {valid, dirty, tag, data} for a given geometry.
  // Packages cannot hold parameterised structs, so each way array declares
  // its own line_t of this width from its parameters.
  function automatic int line_bits(input int tag_w, input int data_w);
    return 2 + tag_w + data_w;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: per-set {valid, dirty, tag, data}. Combinational read,
// synchronous write, async clear of valid/dirty (tag/data are not reset).
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int INDEX_COUNT = 256,
  parameter int IDX_W       = 8,
  parameter int TAG_W       = 24,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  logic [INDEX_COUNT-1:0] valid_q;
  logic [INDEX_COUNT-1:0] dirty_q;
  logic [TAG_W-1:0]       tag_q  [INDEX_COUNT];
  logic [DATA_W-1:0]      data_q [INDEX_COUNT];
  line_t                  rd_line;

  // Status bits: cleared by reset, every write installs a valid line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag/data storage: plain RAM, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Combinational read port.
  always_comb begin
    rd_line.valid = valid_q[rd_idx];
    rd_line.dirty = dirty_q[rd_idx];
    rd_line.tag   = tag_q[rd_idx];
    rd_line.data  = data_q[rd_idx];
  end

  assign rd_valid = rd_line.valid;
  assign rd_dirty = rd_line.dirty;
  assign rd_tag   = rd_line.tag;
  assign rd_data  = rd_line.data;

  localparam int LINE_W = line_bits(TAG_W, DATA_W);
  if ($bits(line_t) != LINE_W) begin : g_line_w_bad
    $error("dcache_way_array: line width mismatch");
  end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative write-back/write-allocate data cache controller.
// One LSU request in flight; dirty victims are written back before refill.
module dcache_assoc_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int INDEX_COUNT = 256,
  parameter int WAYS        = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(INDEX_COUNT);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = way_bits(WAYS);

  state_t state_q, state_d;

  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  logic [WAYS-1:0]             rd_valid, rd_dirty;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0][DATA_W-1:0] rd_data;

  logic [INDEX_COUNT-1:0][WAY_W-1:0] rr_q;
  logic [WAY_W-1:0] ptr_cur, ptr_nxt;
  logic [WAY_W-1:0] victim_q;

  logic             hit, has_inv, use_ptr, victim_dirty;
  logic [WAY_W-1:0] hit_way, inv_way, victim;

  logic              wr_en, wr_dirty;
  logic [WAY_W-1:0]  wr_way;
  logic [DATA_W-1:0] wr_data;

  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W];

  assign ptr_cur = rr_q[req_idx];
  assign ptr_nxt = (ptr_cur == WAY_W'(WAYS - 1)) ? '0 : ptr_cur + 1'b1;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    dcache_way_array #(
      .INDEX_COUNT (INDEX_COUNT),
      .IDX_W       (IDX_W),
      .TAG_W       (TAG_W),
      .DATA_W      (DATA_W)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (req_idx),
      .rd_valid (rd_valid[g]),
      .rd_dirty (rd_dirty[g]),
      .rd_tag   (rd_tag[g]),
      .rd_data  (rd_data[g]),
      .wr_en    (wr_en && (wr_way == WAY_W'(g))),
      .wr_idx   (req_idx),
      .wr_dirty (wr_dirty),
      .wr_tag   (req_tag),
      .wr_data  (wr_data)
    );
  end

  // Tag compare (lowest matching way wins) and victim choice
  // (lowest invalid way, else the set's round-robin pointer).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && rd_valid[w] && (rd_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!has_inv && !rd_valid[w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    use_ptr      = !has_inv;
    victim       = has_inv ? inv_way : ptr_cur;
    victim_dirty = rd_valid[victim] && rd_dirty[victim];
  end

  // Array write port: store hit updates in place, refill installs the victim slot.
  always_comb begin
    wr_en    = 1'b0;
    wr_way   = hit_way;
    wr_dirty = 1'b1;
    wr_data  = req_wdata_q;
    if (state_q == LOOKUP && hit && req_we_q) begin
      wr_en = 1'b1;
    end else if (state_q == REFILL && mem_ready) begin
      wr_en    = 1'b1;
      wr_way   = victim_q;
      wr_dirty = req_we_q;
      wr_data  = req_we_q ? req_wdata_q : mem_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    cpu_rvalid = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit)               state_d = RESPOND;
        else if (victim_dirty) state_d = WRITEBACK;
        else                   state_d = REFILL;
      end
      WRITEBACK: begin
        stall = 1'b1;
        if (mem_ready) state_d = REFILL;
      end
      REFILL: begin
        stall = 1'b1;
        if (mem_ready) state_d = RESPOND;
      end
      RESPOND: begin
        cpu_rvalid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, registered memory port, load data, counters and RR pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      rr_q        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            req_we_q    <= cpu_req_we;
            req_addr_q  <= cpu_addr;
            req_wdata_q <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (!req_we_q)     cpu_rdata <= rd_data[hit_way];
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            victim_q <= victim;
            if (use_ptr) rr_q[req_idx] <= ptr_nxt;
            mem_req <= 1'b1;
            if (victim_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= {rd_tag[victim], req_idx};
              mem_wdata <= rd_data[victim];
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= req_addr_q;
            end
          end
        end
        WRITEBACK: begin
          // Keep mem_req high and swing straight to the refill read.
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= req_addr_q;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!req_we_q) cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Scoreboard bench: a flat architectural memory plus a per-set tag model
// predict load data, memory traffic and counters; monitors check the DUT.
module tb_dcache_assoc_ctrl;

  localparam int AW = 16, DW = 32, NSET = 16, NW = 2, CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpu_req_valid, cpu_req_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready, cpu_rvalid, stall;
  logic [DW-1:0] cpu_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  dcache_assoc_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .INDEX_COUNT(NSET), .WAYS(NW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } mem_exp_t;
  typedef struct { logic [DW-1:0] data; bit chk_lat; int acc_cyc; } rsp_exp_t;
  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];

  logic [DW-1:0] dram   [int];
  logic [DW-1:0] shadow [int];

  // Per-set model state (presence and dirtiness only; data lives in shadow).
  bit            mv [NSET][NW];
  bit            md [NSET][NW];
  logic [11:0]   mt [NSET][NW];
  int            mptr [NSET];
  int            mhit, mmiss;
  logic [DW-1:0] last_load;

  int  issued = 0;
  int  n_done = 0;
  bit  no_resp = 1'b0;

  function automatic logic [DW-1:0] init_val(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] dram_rd(input int a);
    return dram.exists(a) ? dram[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] sh_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSET; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < NW; w++) begin mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0; end
    end
    mhit = 0; mmiss = 0; last_load = '0;
    shadow = dram;  // dirty lines are lost on reset; memory is the truth again
    exp_mem.delete();
    exp_rsp.delete();
  endtask

  // Spec-level cache behaviour: returns hit flag and the expected cpu_rdata.
  task automatic model_access(input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata,
                              output bit hit, output logic [DW-1:0] rdata);
    int s, hw, v;
    logic [11:0] t;
    s = int'(addr[3:0]); t = addr[15:4];
    hit = 0; hw = 0;
    for (int w = 0; w < NW; w++)
      if (!hit && mv[s][w] && mt[s][w] == t) begin hit = 1; hw = w; end
    if (hit) begin
      if (mhit < 15) mhit++;
      if (we) begin md[s][hw] = 1; shadow[int'(addr)] = wdata; end
    end else begin
      if (mmiss < 15) mmiss++;
      v = -1;
      for (int w = 0; w < NW; w++) if (v < 0 && !mv[s][w]) v = w;
      if (v < 0) begin v = mptr[s]; mptr[s] = (mptr[s] + 1) % NW; end
      if (mv[s][v] && md[s][v])
        exp_mem.push_back('{1'b1, {mt[s][v], 4'(s)}, sh_rd(int'({mt[s][v], 4'(s)}))});
      exp_mem.push_back('{1'b0, addr, '0});
      mv[s][v] = 1; mt[s][v] = t; md[s][v] = we;
      if (we) shadow[int'(addr)] = wdata;
    end
    if (we) rdata = last_load;
    else begin rdata = sh_rd(int'(addr)); last_load = rdata; end
  endtask

  task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit hit;
    logic [DW-1:0] exp_d;
    int n;
    model_access(we, addr, wdata, hit, exp_d);
    n = 0;
    @(negedge clk);
    while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
    if (!cpu_ready) fail("cpu_ready_timeout");
    exp_rsp.push_back('{exp_d, hit, cyc});
    issued++;
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (n_done != issued && n < 300) begin @(negedge clk); n++; end
    if (n_done != issued) begin fail("rvalid_timeout"); n_done = issued; end
    chk("hit_cnt", 32'(hit_cnt), 32'(mhit));
    chk("miss_cnt", 32'(miss_cnt), 32'(mmiss));
    chk("mem_traffic_left", 32'(exp_mem.size()), 32'd0);
  endtask

  // Completion monitor: every rvalid pulse must match the head of the queue.
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_rvalid) begin
        if (exp_rsp.size() == 0) fail("spurious_rvalid");
        else begin
          e = exp_rsp.pop_front();
          chk("cpu_rdata", cpu_rdata, e.data);
          if (e.chk_lat) chk("hit_latency", 32'(cyc - e.acc_cyc), 32'd2);
        end
        n_done++;
      end
    end
  end

  // DRAM responder: checks each request, holds it a random time, then completes it.
  initial begin
    mem_exp_t e;
    logic [AW-1:0] a;
    int lat;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && !no_resp) begin
        if (exp_mem.size() == 0) fail("unexpected_mem_req");
        else begin
          e = exp_mem.pop_front();
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
        end
        a = mem_addr;
        lat = $urandom_range(0, 3);
        for (int i = 0; i < lat; i++) begin
          chk("stall_busy", 32'(stall), 32'd1);
          @(negedge clk);
          chk("mem_addr_held", 32'(mem_addr), 32'(a));
        end
        mem_rdata = dram_rd(int'(a));
        if (mem_we) dram[int'(a)] = mem_wdata;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dram[16'h0013] = 32'hDEAD_BEEF;
    dram[16'h0044] = 32'h1111_1111;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_counters", 32'({hit_cnt, miss_cnt}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cpu_ready), 32'd1);

    // Directed: cold miss, hit, store hit, conflict eviction, store-miss eviction.
    do_req(0, 16'h0013, '0);
    do_req(0, 16'h0013, '0);
    do_req(1, 16'h0013, 32'h1234_5678);
    do_req(0, 16'h0013, '0);
    do_req(0, 16'h0023, '0);
    do_req(0, 16'h0033, '0);
    do_req(1, 16'h0044, 32'hCAFE_F00D);
    do_req(0, 16'h0084, '0);
    do_req(0, 16'h00C4, '0);
    do_req(0, 16'h0044, '0);

    // Reset during a refill aborts it.
    no_resp = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_addr = 16'h0055;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!(mem_req && stall) && n < 20) begin @(negedge clk); n++; end
    chk("in_refill", 32'({mem_req, mem_we}), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_resp = 1'b0;
    model_reset();
    n_done = 0; issued = 0;
    @(negedge clk);
    chk("counters_after_abort", 32'({hit_cnt, miss_cnt}), 32'd0);

    // Miss after reset, then 17 hits to saturate hit_cnt.
    do_req(0, 16'h0013, '0);
    for (int i = 0; i < 17; i++) do_req(0, 16'h0013, '0);
    chk("hit_cnt_saturated", 32'(hit_cnt), 32'd15);

    // Randomised traffic over a few conflicting sets plus scattered addresses.
    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 3) == 0) a = AW'($urandom);
      else a = AW'(($urandom_range(0, 5) << 4) | $urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), a, $urandom);
    end

    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_assoc_ctrl.md
# dcache_assoc_ctrl

Parametrised N-way set-associative, write-back/write-allocate data cache controller with integrated tag/data storage. It sits between the LSU (one load/store request at a time) and the DRAM interface. It extends the direct-mapped generation with configurable associativity, dirty-line write-back, per-set round-robin replacement and saturating hit/miss counters.

## Interface
- ADDR_W, 32: word address width.
- DATA_W, 32: data word width; one word per line.
- INDEX_COUNT, 256: sets; power of two, ≥2. IDX_W = log2(INDEX_COUNT), TAG_W = ADDR_W − IDX_W.
- WAYS, 2: associativity; one of 1, 2, 4. WAY_W = max(1, log2(WAYS)).
- CNT_W, 16: hit/miss counter width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  LSU request present.
- cpu_req_we  in  1  1 = store (SW), 0 = load (LW).
- cpu_addr  in  ADDR_W  word address; index = [IDX_W-1:0], tag = [ADDR_W-1:IDX_W].
- cpu_wdata  in  DATA_W  store data.
- cpu_ready  out  1  request accepted when valid & ready.
- cpu_rvalid  out  1  one-cycle completion pulse (load data or store ack).
- cpu_rdata  out  DATA_W  load data, valid with cpu_rvalid.
- stall  out  1  pipeline stall, high while memory traffic is outstanding.
- mem_req  out  1  DRAM request.
- mem_we  out  1  1 = write-back, 0 = refill read.
- mem_addr  out  ADDR_W  DRAM word address.
- mem_wdata  out  DATA_W  write-back data.
- mem_ready  in  1  DRAM completes current transfer this cycle.
- mem_rdata  in  DATA_W  refill data, valid with mem_ready on a read.
- hit_cnt, miss_cnt  out  CNT_W each  saturating counters.

## Operation
- Per line: valid, dirty, tag, data. Per set: round-robin pointer (WAY_W bits).
- FSM: IDLE → LOOKUP → (hit) RESPOND → IDLE; (miss, victim dirty) LOOKUP → WRITEBACK → REFILL → RESPOND; (miss, victim clean/invalid) LOOKUP → REFILL → RESPOND.
- IDLE: cpu_ready=1; on cpu_req_valid, register we/addr/wdata. cpu_ready=0 in all other states.
- LOOKUP: compare tag across all valid ways of the set. Multiple matches cannot occur by construction; if one does, the lowest way wins. Hit: hit_cnt+1; store writes data and sets dirty. Miss: miss_cnt+1; victim = lowest-numbered invalid way, else the way at the set's pointer. The pointer advances (mod WAYS) only when it chose the victim.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. Go to REFILL on mem_ready.
- REFILL: mem_req=1, mem_we=0, mem_addr=request address. On mem_ready, install {valid=1, tag}. A load writes mem_rdata with dirty=0. A store writes cpu_wdata with dirty=1 (whole-word merge).
- RESPOND: cpu_rvalid=1 for one cycle. cpu_rdata = line data for a load; it holds its last value for a store.
- stall = 1 in WRITEBACK and REFILL only.
- Counters saturate at 2^CNT_W − 1 and never wrap.

## Timing
- Reset (asynchronous, immediate): FSM=IDLE; all valid, dirty and pointer bits 0; counters 0; cpu_rvalid, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata and stall all 0. cpu_ready=1 after reset is released. Data/tag arrays are not reset.
- Hit latency: request accepted at cycle T, LOOKUP at T+1, cpu_rvalid at T+2, next accept at T+3.
- Miss latency: T+2+(cycles to each mem_ready) per transfer; cpu_rvalid comes one cycle after the final mem_ready.
- mem_req/mem_we/mem_addr/mem_wdata are registered and held stable until mem_ready is sampled high. mem_ready while mem_req=0 is ignored.
- On the WRITEBACK→REFILL step, mem_req stays high and the new address is presented the next cycle. mem_req drops the cycle after the refill completes.
- Reset asserted mid-transfer aborts it: mem_req drops asynchronously and no line is installed.

## Structure
- dcache_pkg: state_t enum (IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND) and a parametrised-width line struct helper {valid, dirty, tag, data}.
- Sub-module dcache_way_array: one way's storage, with combinational read by index, synchronous write, and an asynchronous clear of valid/dirty. It is instantiated WAYS times by generate.

## Test plan
All scenarios use ADDR_W=16, DATA_W=32, INDEX_COUNT=16, WAYS=2, CNT_W=4.
- Cold load 0x0013, mem_ready 3 cycles after mem_req with 0xDEADBEEF → read mem_addr 0x0013, cpu_rdata 0xDEADBEEF, miss_cnt=1. Reload 0x0013 → cpu_rvalid at T+2, no mem_req, hit_cnt=1.
- Store 0x12345678 to 0x0013 (hit) → no mem traffic. A following load of 0x0013 returns 0x12345678.
- Sequence 0x0013 (dirty), 0x0023, 0x0033 (all set 3) → 0x0023 fills way 1. 0x0033 evicts way 0: write-back mem_addr 0x0013 with data 0x12345678, then refill read 0x0033.
- Store miss 0x0044 with 0xCAFEF00D, refill returning 0x11111111 → after eviction, write-back data is 0xCAFEF00D.
- Assert rst_n low during REFILL → mem_req=0 immediately. After release, load 0x0013 misses and counters read 0.
- 17 consecutive hits → hit_cnt saturates at 15.
